// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding a UART transmitter: buffers bus writes and
// launches one byte per frame through the tx_start/tx_busy/tx_end handshake.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             wr_en_i,
  input  logic [7:0]       wr_data_i,
  input  logic             flush_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o,
  output logic             overflow_o,
  output logic             tx_start_o,
  output logic [7:0]       tx_data_o,
  input  logic             tx_busy_i,
  input  logic             tx_end_i,
  output logic             tx_idle_o
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_END
  } state_e;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q;
  logic             tx_start_q;
  logic [7:0]       tx_data_q;
  state_e           state_q;
  logic             push;
  logic             pop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);

  // full is taken from the registered count, so a same-cycle pop never
  // rescues a push into a full FIFO; flush overrides both directions.
  assign push = wr_en_i && !full_o && !flush_i;
  assign pop  = (state_q == ST_IDLE) && !empty_o && !tx_busy_i && !flush_i;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= wr_en_i && full_o && !flush_i;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_start_q <= 1'b0;
          if (pop) begin
            tx_data_q  <= mem_q[rd_ptr_q];
            tx_start_q <= 1'b1;
            state_q    <= ST_WAIT_END;
          end
        end
        ST_WAIT_END: begin
          // A launched frame always runs to its tx_end, even across a flush.
          tx_start_q <= 1'b0;
          if (tx_end_i) state_q <= ST_IDLE;
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign tx_idle_o  = empty_o && (state_q == ST_IDLE) && !tx_busy_i;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: table-driven fill/overflow vectors, a transmitter
// model, and a scoreboard of expected launched bytes.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int PTR_W = 4;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             flush;
  logic             full;
  logic             empty;
  logic [PTR_W:0]   count;
  logic             overflow;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_busy;
  logic             tx_end;
  logic             tx_idle;

  uart_tx_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk_i      (clk),
    .reset_ni   (rst_n),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .flush_i    (flush),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .overflow_o (overflow),
    .tx_start_o (tx_start),
    .tx_data_o  (tx_data),
    .tx_busy_i  (tx_busy),
    .tx_end_i   (tx_end),
    .tx_idle_o  (tx_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic [7:0] data;
    logic [4:0] exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ovf;
  } vec_t;

  int         total;
  int         bad;
  int         starts;
  int         busy_cnt;
  bit         model_en;
  bit         ovf_seen;
  logic [7:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample just after the edge, score launches, run the transmitter model.
  task automatic tick();
    logic busy_before;
    busy_before = tx_busy;
    @(posedge clk);
    #1;
    if (overflow) ovf_seen = 1'b1;
    if (tx_start) begin
      starts++;
      check("start_while_busy", busy_before, 1'b0);
      if (sb.size() == 0) check("unexpected_start", 1'b1, 1'b0);
      else check("tx_data_order", tx_data, sb.pop_front());
    end
    if (model_en) begin
      tx_end = 1'b0;
      if (tx_start) begin
        tx_busy  = 1'b1;
        busy_cnt = 10;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          tx_busy = 1'b0;
          tx_end  = 1'b1;
        end
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    sb.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!tx_idle && n < budget) begin
      tick();
      n++;
    end
    check(name, tx_idle, 1'b1);
  endtask

  initial begin
    vec_t vecs[18];
    int   s0;
    int   n;

    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b1, 8'(i + 1), 5'(i + 1), (i == 15), 1'b0, 1'b0};
    vecs[16] = '{1'b1, 8'hFF, 5'd16, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 8'h00, 5'd16, 1'b1, 1'b0, 1'b0};

    total = 0; bad = 0; starts = 0; busy_cnt = 0;
    model_en = 1'b0; ovf_seen = 1'b0;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    tx_busy = 1'b0; tx_end = 1'b0;

    #2;
    check("rst_full", full, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_idle", tx_idle, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single byte latency: push at edge N, launch at edge N+1.
    model_en = 1'b1;
    push_byte(8'hA5);
    check("lat_no_start_yet", tx_start, 1'b0);
    check("lat_count_1", count, 1);
    check("lat_not_empty", empty, 1'b0);
    tick();
    check("lat_start", tx_start, 1'b1);
    check("lat_data", tx_data, 8'hA5);
    check("lat_empty_at_launch", empty, 1'b1);
    tick();
    check("lat_start_one_cycle", tx_start, 1'b0);
    check("lat_data_held", tx_data, 8'hA5);
    check("lat_not_idle_busy", tx_idle, 1'b0);
    wait_idle(40, "lat_idle_after_end");

    // Fill to full with the transmitter busy, then a rejected 17th push.
    model_en = 1'b0;
    tx_busy  = 1'b1;
    tx_end   = 1'b0;
    for (int i = 0; i < 18; i++) begin
      wr_en   = vecs[i].wr_en;
      wr_data = vecs[i].data;
      if (vecs[i].wr_en && !vecs[i].exp_ovf) sb.push_back(vecs[i].data);
      tick();
      check($sformatf("fill_count[%0d]", i), count, vecs[i].exp_count);
      check($sformatf("fill_full[%0d]", i), full, vecs[i].exp_full);
      check($sformatf("fill_empty[%0d]", i), empty, vecs[i].exp_empty);
      check($sformatf("fill_ovf[%0d]", i), overflow, vecs[i].exp_ovf);
    end
    wr_en = 1'b0;

    // Drain all 16 through the transmitter model.
    model_en = 1'b1;
    busy_cnt = 0;
    tx_busy  = 1'b0;
    starts   = 0;
    n = 0;
    while (starts < 16 && n < 400) begin
      tick();
      n++;
    end
    check("drain_starts", starts, 16);
    check("drain_empty", empty, 1'b1);
    wait_idle(40, "drain_idle");
    check("drain_sb_empty", sb.size(), 0);

    // Second fill of 20 bytes, paced so it never overflows; pointers wrap again.
    starts   = 0;
    ovf_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push_byte(8'(8'h50 + i));
      tick();
      tick();
    end
    n = 0;
    while (starts < 20 && n < 400) begin
      tick();
      n++;
    end
    check("wrap_starts", starts, 20);
    check("wrap_no_overflow", ovf_seen, 1'b0);
    wait_idle(40, "wrap_idle");

    // Push and launch in the same cycle with count=5.
    model_en = 1'b0;
    tx_busy  = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h31 + i));
    check("simul_count_before", count, 5);
    wr_en    = 1'b1;
    wr_data  = 8'h36;
    sb.push_back(8'h36);
    tx_busy  = 1'b0;
    model_en = 1'b1;
    busy_cnt = 0;
    tick();
    wr_en = 1'b0;
    check("simul_launch", tx_start, 1'b1);
    check("simul_count_after", count, 5);
    wait_idle(200, "simul_idle");
    check("simul_sb_empty", sb.size(), 0);

    // Flush while waiting for the end of a frame with 3 bytes queued.
    model_en = 1'b0;
    tx_busy  = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(8'(8'h41 + i));
    tx_busy = 1'b0;
    tick();
    tx_busy = 1'b1;
    check("flush_launch", tx_start, 1'b1);
    check("flush_count_before", count, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    check("flush_count", count, 0);
    check("flush_empty", empty, 1'b1);
    check("flush_no_ovf", overflow, 1'b0);
    s0 = starts;
    tx_busy = 1'b0;
    repeat (4) tick();
    check("flush_wait_end_not_idle", tx_idle, 1'b0);
    tx_end = 1'b1;
    tick();
    tx_end = 1'b0;
    tick();
    check("flush_idle", tx_idle, 1'b1);
    check("flush_no_start", starts, s0);

    // Asynchronous reset mid-frame with count=4.
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h61 + i));
    tx_busy = 1'b0;
    tick();
    tx_busy = 1'b1;
    check("arst_count_before", count, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1'b1);
    check("arst_full", full, 1'b0);
    check("arst_tx_start", tx_start, 1'b0);
    check("arst_tx_data", tx_data, 8'h00);
    check("arst_overflow", overflow, 1'b0);
    tx_busy = 1'b0;
    #1;
    check("arst_tx_idle", tx_idle, 1'b1);
    sb.delete();
    #2;
    rst_n = 1'b1;
    s0 = starts;
    repeat (6) tick();
    check("arst_no_start", starts, s0);
    model_en = 1'b1;
    busy_cnt = 0;
    push_byte(8'h77);
    tick();
    check("arst_relaunch", tx_start, 1'b1);
    wait_idle(40, "arst_idle");
    check("arst_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side byte buffer that sits directly upstream of the UART transmitter and absorbs bursts of bus writes.
- It accepts bytes from the UART control/bus logic, stores them in a circular FIFO, and launches them one at a time into the transmitter through its tx_start/tx_data/tx_busy/tx_end handshake.
- It reports occupancy, overflow and all-sent status for interrupt generation.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, at least 2.
- PTR_W, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  push request from control logic; one byte per cycle.
- wr_data  input  8  byte to push.
- flush  input  1  synchronous clear of FIFO contents.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse when a push is rejected.
- tx_start  output  1  one-cycle launch strobe to the transmitter.
- tx_data  output  8  byte being launched; valid while tx_start is high, then held.
- tx_busy  input  1  transmitter is shifting a frame.
- tx_end  input  1  one-cycle pulse marking the end of a frame.
- tx_idle  output  1  FIFO empty, FSM in IDLE, and tx_busy low (all data sent).

Behaviour:
- Reset (reset low, asynchronous):
  - Read and write pointers are cleared, and count is 0.
  - FSM is in IDLE.
  - Outputs: full=0, empty=1, overflow=0, tx_start=0, tx_data=8'h00, tx_idle=1. This is combinational from the reset state and tx_busy; tx_busy is 0 out of reset.
- Storage: circular buffer of DEPTH x 8 registers. Write and read pointers are PTR_W bits and wrap from DEPTH-1 to 0. count is a separate PTR_W+1-bit register.
- Push: when wr_en=1 and full=0, wr_data is written at the write pointer on the clock edge, and the write pointer increments modulo DEPTH.
- Rejected push: when wr_en=1 and full=1, the data is dropped and overflow is registered high for exactly the next cycle. This holds even if a pop occurs in the same cycle, i.e. full is evaluated before the pop.
- Pop: happens only inside the launch FSM; the read pointer increments modulo DEPTH.
- count update:
  - +1 on an accepted push only.
  - -1 on a pop only.
  - Unchanged on simultaneous push and pop.
- full and empty are decoded combinationally from count (count==DEPTH, count==0).
- Launch FSM, two states:
  - IDLE: if empty=0 and tx_busy=0, then on the edge:
    - tx_data <= entry at the read pointer;
    - tx_start <= 1;
    - pop;
    - go to WAIT_END.
    Otherwise stay in IDLE.
  - WAIT_END: tx_start <= 0. On tx_end=1, return to IDLE. Otherwise stay.
- Back-to-back bytes: a tx_end pulse seen in WAIT_END returns the FSM to IDLE; the next tx_start can be issued on the following edge once tx_busy=0. A new tx_start is never issued while tx_busy=1.
- Latency: a byte pushed into an empty FIFO with the FSM in IDLE and tx_busy=0 produces tx_start high in the second cycle after the wr_en cycle. The push is registered at edge N and the launch is registered at edge N+1.
- Flush:
  - When flush=1, on the edge both pointers are cleared and count becomes 0.
  - flush has priority over a push and over a pop in the same cycle: an IDLE launch that cycle is suppressed, and tx_start stays 0.
  - A frame already launched is not aborted. The FSM remains in WAIT_END until tx_end.
- overflow is not asserted by flush.
- tx_data holds its last launched value between launches.
- tx_end received while in IDLE is ignored.

Test Plan:
- Reset, then push 8'hA5 with tx_busy=0 -> tx_start=1 for one cycle, two cycles after wr_en, with tx_data=8'hA5. empty=1 from the launch edge onward. tx_idle=1 after tx_end.
- Push 8'h01..8'h10 (16 bytes) in consecutive cycles while tx_busy is held high -> full=1, count=16. A 17th push of 8'hFF gives an overflow pulse of 1 cycle, and count stays 16.
- Drain the full FIFO with a transmitter model (busy for 10 cycles, then a tx_end pulse) -> 16 tx_start pulses carrying 8'h01..8'h10 in order, each issued only while tx_busy=0. Pointer wrap is exercised by a second fill of 20 bytes.
- With count=5, assert wr_en and launch in the same cycle -> count stays 5 and the pushed byte appears in the correct position.
- Assert flush during WAIT_END with count=3 -> count=0, empty=1, no further tx_start. The FSM returns to IDLE on tx_end, and tx_idle=1 after that.
- Assert reset low asynchronously mid-frame with count=4 -> outputs go to their reset values immediately, without waiting for a clock edge. After release, no tx_start occurs until a new push.
